conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, token buffer depth (power of two, >=2).
REQ-002 Parameter ACK_TIMEOUT, default 255, max cycles a strobe is held waiting for converter BUSY.
REQ-003 CLK  in  1  single clock; all state on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 TOK_VALID  in  1  upstream token valid.
REQ-006 TOK_READY  out  1  sequencer can accept a token.
REQ-007 TOK_KIND  in  2  00 number, 01 operator, 10 end-of-expression, 11 reserved.
REQ-008 TOK_DATA  in  8  number value or operator ASCII code.
REQ-009 INPUT_SIGN  out  8  operator to converter.
REQ-010 INPUT_NUMBER  out  8  number to converter.
REQ-011 SIGN_STB  out  1  operator strobe to converter.
REQ-012 NUMBER_STB  out  1  number strobe to converter.
REQ-013 CONV_BUSY  in  1  converter BUSY.
REQ-014 CLR_ERR  in  1  synchronous clear of sticky error flags.
REQ-015 ERR_OP  out  1  sticky: invalid operator/reserved kind dropped.
REQ-016 ERR_TIMEOUT  out  1  sticky: strobe unacknowledged for ACK_TIMEOUT cycles.
REQ-017 ISSUED_CNT  out  16  tokens acknowledged by converter.
REQ-018 SEQ_IDLE  out  1  FSM in IDLE and FIFO empty.

Function
REQ-019 FIFO: push on TOK_VALID && TOK_READY; TOK_READY = !full, registered-state only, no combinational dependence on same-cycle pop (full + pop same cycle -> no accept).
REQ-020 FSM states IDLE, ACK, DONE; encoding internal.
REQ-021 IDLE: if FIFO non-empty and CONV_BUSY==0, pop head at next edge; if head valid, load INPUT_SIGN/INPUT_NUMBER, assert strobe(s), go ACK; else stay IDLE.
REQ-022 Kind 00 -> INPUT_NUMBER=data, NUMBER_STB=1; kind 01 with data in {'+','-','*','/'} -> INPUT_SIGN=data, SIGN_STB=1; kind 10 -> both strobes =1, data outputs unchanged.
REQ-023 Kind 01 with other data, or kind 11: popped, no strobe, ERR_OP set, FSM stays IDLE.
REQ-024 Latency: token accepted into empty FIFO at edge n with FSM IDLE and CONV_BUSY low -> strobe high after edge n+1.
REQ-025 ACK: strobes and data held stable; CONV_BUSY sampled 1 -> strobes cleared next edge, ISSUED_CNT+1 (wraps 0xFFFF->0), go DONE.
REQ-026 ACK timer counts cycles in ACK; reaching ACK_TIMEOUT without BUSY -> strobes cleared, ERR_TIMEOUT set, token discarded, go IDLE; BUSY in same cycle as expiry counts as ack.
REQ-027 DONE: wait CONV_BUSY==0, then IDLE; no new strobe while BUSY high.
REQ-028 Never more than one outstanding token; SIGN_STB and NUMBER_STB high together only for kind 10.
REQ-029 CLR_ERR clears both sticky flags; set event in same cycle wins.
REQ-030 Upstream push allowed in any state, including ACK/DONE.

Reset
REQ-031 RST_N low: FIFO emptied, FSM IDLE, timer 0, strobes 0, INPUT_SIGN/INPUT_NUMBER 0, ERR flags 0, ISSUED_CNT 0, TOK_READY 0 while RST_N low, 1 from first edge after release.
REQ-032 Reset mid-ACK drops outstanding strobe immediately (asynchronous); token lost, no count.

Structure
REQ-033 Shared package holds token-kind enum, FSM state enum, operator ASCII constants.
REQ-034 FIFO is one sub-module, conv_tok_fifo (parameterised depth/width 10 bits).

Verification
REQ-035 Push number 5, BUSY pulses 1 cycle after strobe -> NUMBER_STB high 1 edge after accept, INPUT_NUMBER=5, dropped after BUSY, ISSUED_CNT=1.
REQ-036 Push '+' then '%' -> SIGN_STB with INPUT_SIGN=0x2B; '%' dropped, ERR_OP=1, ISSUED_CNT=1; CLR_ERR -> ERR_OP=0.
REQ-037 BUSY held low, ACK_TIMEOUT=8 -> strobe high exactly 8 cycles, ERR_TIMEOUT=1, FSM IDLE, count unchanged.
REQ-038 Push 5 tokens with BUSY stuck high -> TOK_READY=0 after 4, 5th held until a pop; no strobe while BUSY high.
REQ-039 End token -> SIGN_STB and NUMBER_STB high same cycle, both dropped on BUSY.
REQ-040 RST_N low during ACK -> strobes 0 without clock edge; after release SEQ_IDLE=1, ISSUED_CNT=0.

Source files
------------

// File: rtl/conv_sequencer_pkg.sv
// conv_sequencer_pkg
// Shared definitions for the token-to-converter sequencer slice.
//   - tok_kind_e  : 2-bit token kind carried alongside each byte
//   - seq_state_e : sequencer FSM states
//   - OP_*        : ASCII codes of the operators the converter accepts
//   - is_operator : true when a byte is one of the accepted operators
package conv_sequencer_pkg;

    localparam int TOK_KIND_W = 2;
    localparam int TOK_DATA_W = 8;
    localparam int TOK_W      = TOK_KIND_W + TOK_DATA_W;

    typedef enum logic [1:0] {
        KIND_NUMBER   = 2'b00,
        KIND_OPERATOR = 2'b01,
        KIND_END      = 2'b10,
        KIND_RESERVED = 2'b11
    } tok_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK  = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    localparam logic [7:0] OP_ADD = 8'h2B;  // '+'
    localparam logic [7:0] OP_SUB = 8'h2D;  // '-'
    localparam logic [7:0] OP_MUL = 8'h2A;  // '*'
    localparam logic [7:0] OP_DIV = 8'h2F;  // '/'

    function automatic logic is_operator(input logic [7:0] code);
        return (code == OP_ADD) || (code == OP_SUB) ||
               (code == OP_MUL) || (code == OP_DIV);
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if
// Bundles the upstream token handshake and the converter strobe bus.
//   Token side    : TOK_VALID, TOK_KIND, TOK_DATA (to sequencer), TOK_READY (from sequencer)
//   Converter side: INPUT_SIGN, INPUT_NUMBER, SIGN_STB, NUMBER_STB (from sequencer),
//                   CONV_BUSY (to sequencer)
// Modports:
//   slave  - the sequencer's view
//   master - the environment's view (token producer + converter)
interface conv_sequencer_if;
    import conv_sequencer_pkg::*;

    logic                  TOK_VALID;
    logic                  TOK_READY;
    logic [TOK_KIND_W-1:0] TOK_KIND;
    logic [TOK_DATA_W-1:0] TOK_DATA;

    logic [7:0]            INPUT_SIGN;
    logic [7:0]            INPUT_NUMBER;
    logic                  SIGN_STB;
    logic                  NUMBER_STB;
    logic                  CONV_BUSY;

    modport slave (
        input  TOK_VALID, TOK_KIND, TOK_DATA, CONV_BUSY,
        output TOK_READY, INPUT_SIGN, INPUT_NUMBER, SIGN_STB, NUMBER_STB
    );

    modport master (
        output TOK_VALID, TOK_KIND, TOK_DATA, CONV_BUSY,
        input  TOK_READY, INPUT_SIGN, INPUT_NUMBER, SIGN_STB, NUMBER_STB
    );

endinterface

// File: rtl/conv_tok_fifo.sv
// conv_tok_fifo
// Small synchronous FIFO holding {kind, data} tokens between the upstream
// producer and the sequencer FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head_data  : current head entry (valid when !empty)
//   empty/full : derived from the registered occupancy count only
module conv_tok_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer
// Feeds a stream of expression tokens to a converter one at a time using a
// strobe / BUSY acknowledge protocol.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   bus (slave)  : token handshake in, converter strobes/data out, CONV_BUSY in
//   CLR_ERR      : synchronous clear of the sticky error flags
//   ERR_OP       : sticky, an invalid operator or reserved-kind token was dropped
//   ERR_TIMEOUT  : sticky, a strobe went unacknowledged for ACK_TIMEOUT cycles
//   ISSUED_CNT   : tokens acknowledged by the converter (wraps)
//   SEQ_IDLE     : FSM idle and token buffer empty
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    conv_sequencer_if.slave         bus,
    input  logic                    CLR_ERR,
    output logic                    ERR_OP,
    output logic                    ERR_TIMEOUT,
    output logic [15:0]             ISSUED_CNT,
    output logic                    SEQ_IDLE
);

    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

    seq_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               sign_stb_q, sign_stb_d;
    logic               num_stb_q, num_stb_d;
    logic [7:0]         sign_q, sign_d;
    logic [7:0]         num_q, num_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               err_op_q, err_op_d;
    logic               err_to_q, err_to_d;
    logic               err_op_set;
    logic               err_to_set;
    logic               ready_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic [TOK_W-1:0]   fifo_head;
    logic               fifo_empty;
    logic               fifo_full;
    tok_kind_e          head_kind;
    logic [7:0]         head_byte;

    // Ready is held low through reset and only rises on the first edge after
    // release; it depends on registered occupancy only, so a same-cycle pop
    // never lets a full buffer accept.
    assign bus.TOK_READY = ready_q && !fifo_full;
    assign fifo_push     = bus.TOK_VALID && bus.TOK_READY;

    assign head_kind = tok_kind_e'(fifo_head[TOK_W-1 -: TOK_KIND_W]);
    assign head_byte = fifo_head[TOK_DATA_W-1:0];

    conv_tok_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TOK_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (fifo_push),
        .push_data ({bus.TOK_KIND, bus.TOK_DATA}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            sign_stb_q <= 1'b0;
            num_stb_q  <= 1'b0;
            sign_q     <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            err_op_q   <= 1'b0;
            err_to_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sign_stb_q <= sign_stb_d;
            num_stb_q  <= num_stb_d;
            sign_q     <= sign_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            err_op_q   <= err_op_d;
            err_to_q   <= err_to_d;
            ready_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sign_stb_d = sign_stb_q;
        num_stb_d  = num_stb_q;
        sign_d     = sign_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        err_op_set = 1'b0;
        err_to_set = 1'b0;
        fifo_pop   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !bus.CONV_BUSY) begin
                    fifo_pop = 1'b1;
                    timer_d  = '0;
                    unique case (head_kind)
                        KIND_NUMBER: begin
                            num_d     = head_byte;
                            num_stb_d = 1'b1;
                            state_d   = ST_ACK;
                        end
                        KIND_OPERATOR: begin
                            if (is_operator(head_byte)) begin
                                sign_d     = head_byte;
                                sign_stb_d = 1'b1;
                                state_d    = ST_ACK;
                            end else begin
                                err_op_set = 1'b1;
                            end
                        end
                        // End-of-expression strobes both lines with the data
                        // registers left as they were.
                        KIND_END: begin
                            sign_stb_d = 1'b1;
                            num_stb_d  = 1'b1;
                            state_d    = ST_ACK;
                        end
                        default: begin
                            err_op_set = 1'b1;
                        end
                    endcase
                end
            end
            // BUSY is checked before expiry so an ack on the last cycle wins.
            ST_ACK: begin
                if (bus.CONV_BUSY) begin
                    sign_stb_d = 1'b0;
                    num_stb_d  = 1'b0;
                    cnt_d      = cnt_q + 16'd1;
                    state_d    = ST_DONE;
                end else if (timer_q == TIMER_W'(ACK_TIMEOUT - 1)) begin
                    sign_stb_d = 1'b0;
                    num_stb_d  = 1'b0;
                    err_to_set = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_DONE: begin
                if (!bus.CONV_BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A set event in the same cycle as a clear leaves the flag set.
        err_op_d = err_op_set ? 1'b1 : (CLR_ERR ? 1'b0 : err_op_q);
        err_to_d = err_to_set ? 1'b1 : (CLR_ERR ? 1'b0 : err_to_q);
    end

    assign bus.SIGN_STB     = sign_stb_q;
    assign bus.NUMBER_STB   = num_stb_q;
    assign bus.INPUT_SIGN   = sign_q;
    assign bus.INPUT_NUMBER = num_q;
    assign ERR_OP           = err_op_q;
    assign ERR_TIMEOUT      = err_to_q;
    assign ISSUED_CNT       = cnt_q;
    assign SEQ_IDLE         = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer
// Directed bench for conv_sequencer with FIFO_DEPTH=4, ACK_TIMEOUT=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_conv_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        CLR_ERR;
    logic        ERR_OP;
    logic        ERR_TIMEOUT;
    logic [15:0] ISSUED_CNT;
    logic        SEQ_IDLE;

    int checks = 0;
    int errors = 0;

    conv_sequencer_if bus ();

    conv_sequencer #(
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (8)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus.slave),
        .CLR_ERR     (CLR_ERR),
        .ERR_OP      (ERR_OP),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .ISSUED_CNT  (ISSUED_CNT),
        .SEQ_IDLE    (SEQ_IDLE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] kind,
                                  input logic [7:0] data);
        bus.TOK_VALID = valid;
        bus.TOK_KIND  = kind;
        bus.TOK_DATA  = data;
    endtask

    // Presents one token for a single edge; returns on the falling edge after it.
    task automatic push_token(input logic [1:0] kind, input logic [7:0] data);
        apply_stimulus(1'b1, kind, data);
        @(negedge CLK);
        apply_stimulus(1'b0, 2'b00, 8'h00);
    endtask

    task automatic wait_number_stb(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge CLK);
            if (bus.NUMBER_STB) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen;

        RST_N         = 1'b0;
        CLR_ERR       = 1'b0;
        bus.CONV_BUSY = 1'b0;
        apply_stimulus(1'b0, 2'b00, 8'h00);

        // Reset state
        #1;
        check_output("rst_ready",    32'(bus.TOK_READY),  32'h0);
        check_output("rst_nstb",     32'(bus.NUMBER_STB), 32'h0);
        check_output("rst_sstb",     32'(bus.SIGN_STB),   32'h0);
        check_output("rst_cnt",      32'(ISSUED_CNT),     32'h0);
        check_output("rst_errop",    32'(ERR_OP),         32'h0);
        check_output("rst_idle",     32'(SEQ_IDLE),       32'h1);
        @(negedge CLK);
        @(negedge CLK);
        check_output("rst_ready_held", 32'(bus.TOK_READY), 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        check_output("ready_after_rst", 32'(bus.TOK_READY), 32'h1);

        // Number 5 with a one-cycle BUSY ack
        push_token(2'b00, 8'd5);
        check_output("num_latency_low", 32'(bus.NUMBER_STB), 32'h0);
        @(negedge CLK);
        check_output("num_stb",   32'(bus.NUMBER_STB),   32'h1);
        check_output("num_val",   32'(bus.INPUT_NUMBER), 32'd5);
        check_output("num_sstb",  32'(bus.SIGN_STB),     32'h0);
        bus.CONV_BUSY = 1'b1;
        @(negedge CLK);
        check_output("num_dropped", 32'(bus.NUMBER_STB), 32'h0);
        check_output("num_cnt",     32'(ISSUED_CNT),     32'd1);
        bus.CONV_BUSY = 1'b0;
        @(negedge CLK);
        check_output("num_idle",    32'(SEQ_IDLE),       32'h1);

        // '+' accepted, '%' dropped with ERR_OP
        push_token(2'b01, 8'h2B);
        push_token(2'b01, 8'h25);
        check_output("op_sstb",  32'(bus.SIGN_STB),   32'h1);
        check_output("op_sign",  32'(bus.INPUT_SIGN), 32'h2B);
        check_output("op_nstb",  32'(bus.NUMBER_STB), 32'h0);
        bus.CONV_BUSY = 1'b1;
        @(negedge CLK);
        check_output("op_dropped", 32'(bus.SIGN_STB), 32'h0);
        check_output("op_cnt",     32'(ISSUED_CNT),   32'd2);
        bus.CONV_BUSY = 1'b0;
        @(negedge CLK);
        check_output("op_err_before", 32'(ERR_OP), 32'h0);
        @(negedge CLK);
        check_output("op_err_set",   32'(ERR_OP),       32'h1);
        check_output("op_bad_nostb", 32'(bus.SIGN_STB), 32'h0);
        check_output("op_bad_idle",  32'(SEQ_IDLE),     32'h1);
        check_output("op_bad_cnt",   32'(ISSUED_CNT),   32'd2);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        check_output("op_err_clr", 32'(ERR_OP), 32'h0);
        CLR_ERR = 1'b0;

        // Reserved kind, then reserved kind popped while clearing
        push_token(2'b11, 8'h00);
        @(negedge CLK);
        check_output("rsvd_err", 32'(ERR_OP), 32'h1);
        push_token(2'b11, 8'h12);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        check_output("set_wins_clr", 32'(ERR_OP), 32'h1);
        @(negedge CLK);
        check_output("clr_after", 32'(ERR_OP), 32'h0);
        CLR_ERR = 1'b0;

        // Timeout: BUSY held low, strobe high for exactly 8 cycles
        push_token(2'b00, 8'h33);
        @(negedge CLK);
        check_output("to_err_before", 32'(ERR_TIMEOUT), 32'h0);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("to_stb_%0d", i), 32'(bus.NUMBER_STB), 32'h1);
            @(negedge CLK);
        end
        check_output("to_stb_off", 32'(bus.NUMBER_STB), 32'h0);
        check_output("to_err",     32'(ERR_TIMEOUT),    32'h1);
        check_output("to_idle",    32'(SEQ_IDLE),       32'h1);
        check_output("to_cnt",     32'(ISSUED_CNT),     32'd2);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        check_output("to_err_clr", 32'(ERR_TIMEOUT), 32'h0);
        CLR_ERR = 1'b0;

        // End-of-expression strobes both lines, data unchanged
        push_token(2'b10, 8'h99);
        @(negedge CLK);
        check_output("end_sstb", 32'(bus.SIGN_STB),     32'h1);
        check_output("end_nstb", 32'(bus.NUMBER_STB),   32'h1);
        check_output("end_num",  32'(bus.INPUT_NUMBER), 32'h33);
        check_output("end_sign", 32'(bus.INPUT_SIGN),   32'h2B);
        bus.CONV_BUSY = 1'b1;
        @(negedge CLK);
        check_output("end_sdrop", 32'(bus.SIGN_STB),   32'h0);
        check_output("end_ndrop", 32'(bus.NUMBER_STB), 32'h0);
        check_output("end_cnt",   32'(ISSUED_CNT),     32'd3);
        bus.CONV_BUSY = 1'b0;
        @(negedge CLK);
        check_output("end_idle", 32'(SEQ_IDLE), 32'h1);

        // Fill the buffer while BUSY is stuck high
        bus.CONV_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 2'b00, 8'(i + 1));
            @(negedge CLK);
        end
        check_output("full_ready", 32'(bus.TOK_READY), 32'h0);
        apply_stimulus(1'b1, 2'b00, 8'd5);
        @(negedge CLK);
        @(negedge CLK);
        check_output("full_ready_held", 32'(bus.TOK_READY),  32'h0);
        check_output("full_no_nstb",    32'(bus.NUMBER_STB), 32'h0);
        check_output("full_no_sstb",    32'(bus.SIGN_STB),   32'h0);
        bus.CONV_BUSY = 1'b0;
        @(negedge CLK);
        check_output("full_pop_stb",   32'(bus.NUMBER_STB),   32'h1);
        check_output("full_pop_val",   32'(bus.INPUT_NUMBER), 32'd1);
        check_output("full_pop_ready", 32'(bus.TOK_READY),    32'h1);
        bus.CONV_BUSY = 1'b1;
        @(negedge CLK);
        apply_stimulus(1'b0, 2'b00, 8'h00);
        check_output("fifth_in_full", 32'(bus.TOK_READY),  32'h0);
        check_output("fifth_nostb",   32'(bus.NUMBER_STB), 32'h0);
        check_output("fifth_cnt",     32'(ISSUED_CNT),     32'd4);
        bus.CONV_BUSY = 1'b0;
        for (int v = 2; v <= 5; v++) begin
            wait_number_stb(6, seen);
            check_output($sformatf("drain_seen_%0d", v), 32'(seen), 32'h1);
            check_output($sformatf("drain_val_%0d", v), 32'(bus.INPUT_NUMBER), 32'(v));
            bus.CONV_BUSY = 1'b1;
            @(negedge CLK);
            check_output($sformatf("drain_drop_%0d", v), 32'(bus.NUMBER_STB), 32'h0);
            bus.CONV_BUSY = 1'b0;
        end
        check_output("drain_cnt", 32'(ISSUED_CNT), 32'd8);
        @(negedge CLK);
        check_output("drain_idle", 32'(SEQ_IDLE), 32'h1);

        // Asynchronous reset in the middle of ACK
        push_token(2'b00, 8'h77);
        @(negedge CLK);
        check_output("ack_before_rst", 32'(bus.NUMBER_STB), 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        check_output("rst_async_nstb",  32'(bus.NUMBER_STB), 32'h0);
        check_output("rst_async_sstb",  32'(bus.SIGN_STB),   32'h0);
        check_output("rst_async_ready", 32'(bus.TOK_READY),  32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check_output("post_rst_idle",  32'(SEQ_IDLE),         32'h1);
        check_output("post_rst_cnt",   32'(ISSUED_CNT),       32'h0);
        check_output("post_rst_ready", 32'(bus.TOK_READY),    32'h1);
        check_output("post_rst_num",   32'(bus.INPUT_NUMBER), 32'h0);
        check_output("post_rst_nstb",  32'(bus.NUMBER_STB),   32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
